// File: rtl/sal_dfi_cmd_decoder.sv
// sal_dfi_cmd_decoder: DDR2 DFI command decoder and protocol/timing checker.
// In: dfi_* command bus, t_* timing values (clk cycles), err_clr_i.
// Out: registered cmd_*, bank_open_o, err_pulse_o, sticky err_o/err_code_o.
module sal_dfi_cmd_decoder #(
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W    = 14,
  parameter int TW        = 8,
  parameter int BA_W      = $clog2(NUM_BANKS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dfi_cke,
  input  logic                 dfi_cs_n,
  input  logic                 dfi_ras_n,
  input  logic                 dfi_cas_n,
  input  logic                 dfi_we_n,
  input  logic [BA_W-1:0]      dfi_ba,
  input  logic [ADDR_W-1:0]    dfi_addr,
  input  logic [TW-1:0]        t_rcd,
  input  logic [TW-1:0]        t_rp,
  input  logic [TW-1:0]        t_ras,
  input  logic [TW-1:0]        t_rfc,
  input  logic [TW-1:0]        t_rtp,
  input  logic [TW-1:0]        t_wtp,
  input  logic [TW-1:0]        t_rrd,
  input  logic [TW-1:0]        t_ccd,
  input  logic                 err_clr_i,
  output logic                 cmd_valid_o,
  output logic [2:0]           cmd_o,
  output logic [BA_W-1:0]      cmd_ba_o,
  output logic [ADDR_W-1:0]    cmd_addr_o,
  output logic [NUM_BANKS-1:0] bank_open_o,
  output logic                 err_pulse_o,
  output logic                 err_o,
  output logic [3:0]           err_code_o
);

  typedef enum logic [2:0] {
    C_NOP  = 3'd0,
    C_ACT  = 3'd1,
    C_RD   = 3'd2,
    C_WR   = 3'd3,
    C_PRE  = 3'd4,
    C_PREA = 3'd5,
    C_REF  = 3'd6,
    C_MRS  = 3'd7
  } cmd_e;

  // Counters hold t-1 after the command edge, so a value of 0
  // means the constraint is met on the next sampled command.
  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  logic [NUM_BANKS-1:0] open_q, open_d;
  logic [TW-1:0] rcd_q [NUM_BANKS];
  logic [TW-1:0] rcd_d [NUM_BANKS];
  logic [TW-1:0] rp_q  [NUM_BANKS];
  logic [TW-1:0] rp_d  [NUM_BANKS];
  logic [TW-1:0] ras_q [NUM_BANKS];
  logic [TW-1:0] ras_d [NUM_BANKS];
  logic [TW-1:0] rtp_q [NUM_BANKS];
  logic [TW-1:0] rtp_d [NUM_BANKS];
  logic [TW-1:0] wtp_q [NUM_BANKS];
  logic [TW-1:0] wtp_d [NUM_BANKS];
  logic [TW-1:0] rfc_q, rfc_d;
  logic [TW-1:0] rrd_q, rrd_d;
  logic [TW-1:0] ccd_q, ccd_d;

  logic              valid_q, valid_d;
  cmd_e              cmd_q, cmd_d;
  logic [BA_W-1:0]   ba_q, ba_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pulse_q, pulse_d;
  logic              err_q, err_d;
  logic [3:0]        code_q, code_d;

  cmd_e        cmd;
  logic        illegal;
  logic        pdn;
  logic        col;
  logic        any_open;
  logic        any_rp;
  logic        pre_ras, pre_rtp, pre_wtp;
  logic [14:1] err_vec;
  logic [3:0]  code;

  always_comb begin
    cmd     = C_NOP;
    illegal = 1'b0;
    pdn     = 1'b0;
    if (!dfi_cs_n) begin
      if (!dfi_cke) begin
        pdn = 1'b1;
      end else begin
        case ({dfi_ras_n, dfi_cas_n, dfi_we_n})
          3'b000:  cmd = C_MRS;
          3'b001:  cmd = C_REF;
          3'b010:  cmd = dfi_addr[10] ? C_PREA : C_PRE;
          3'b011:  cmd = C_ACT;
          3'b100:  cmd = C_WR;
          3'b101:  cmd = C_RD;
          3'b110:  illegal = 1'b1;
          default: cmd = C_NOP;
        endcase
      end
    end
  end

  always_comb begin
    col      = (cmd == C_RD) || (cmd == C_WR);
    any_open = |open_q;
    any_rp   = 1'b0;
    pre_ras  = 1'b0;
    pre_rtp  = 1'b0;
    pre_wtp  = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      any_rp = any_rp | (rp_q[b] != '0);
      // PREA checks every open bank; PRE only the addressed one
      if (open_q[b] && ((cmd == C_PREA) ||
          (cmd == C_PRE && dfi_ba == BA_W'(b)))) begin
        pre_ras = pre_ras | (ras_q[b] != '0);
        pre_rtp = pre_rtp | (rtp_q[b] != '0);
        pre_wtp = pre_wtp | (wtp_q[b] != '0);
      end
    end

    err_vec     = '0;
    err_vec[1]  = (cmd == C_ACT) && open_q[dfi_ba];
    err_vec[2]  = col && !open_q[dfi_ba];
    err_vec[3]  = col && (rcd_q[dfi_ba] != '0);
    err_vec[4]  = ((cmd == C_ACT) && (rp_q[dfi_ba] != '0)) ||
                  ((cmd == C_REF) && any_rp);
    err_vec[5]  = pre_ras;
    err_vec[6]  = pre_rtp;
    err_vec[7]  = pre_wtp;
    err_vec[8]  = ((cmd == C_ACT) || (cmd == C_REF)) && (rfc_q != '0);
    err_vec[9]  = (cmd == C_ACT) && (rrd_q != '0);
    err_vec[10] = col && (ccd_q != '0);
    err_vec[11] = ((cmd == C_REF) || (cmd == C_MRS)) && any_open;
    err_vec[12] = illegal;
    err_vec[13] = pdn;
    err_vec[14] = col && dfi_addr[10];

    // descending scan so the lowest set code is the one kept
    code = '0;
    for (int i = 14; i >= 1; i--) begin
      if (err_vec[i]) code = 4'(i);
    end
  end

  always_comb begin
    open_d = open_q;
    rfc_d  = sat_dec(rfc_q);
    rrd_d  = sat_dec(rrd_q);
    ccd_d  = sat_dec(ccd_q);
    for (int b = 0; b < NUM_BANKS; b++) begin
      rcd_d[b] = sat_dec(rcd_q[b]);
      rp_d[b]  = sat_dec(rp_q[b]);
      ras_d[b] = sat_dec(ras_q[b]);
      rtp_d[b] = sat_dec(rtp_q[b]);
      wtp_d[b] = sat_dec(wtp_q[b]);
    end
    case (cmd)
      C_ACT: begin
        open_d[dfi_ba] = 1'b1;
        rcd_d[dfi_ba]  = sat_dec(t_rcd);
        ras_d[dfi_ba]  = sat_dec(t_ras);
        rrd_d          = sat_dec(t_rrd);
      end
      C_RD: begin
        rtp_d[dfi_ba] = sat_dec(t_rtp);
        ccd_d         = sat_dec(t_ccd);
      end
      C_WR: begin
        wtp_d[dfi_ba] = sat_dec(t_wtp);
        ccd_d         = sat_dec(t_ccd);
      end
      C_PRE: begin
        open_d[dfi_ba] = 1'b0;
        rp_d[dfi_ba]   = sat_dec(t_rp);
      end
      C_PREA: begin
        open_d = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
          rp_d[b] = sat_dec(t_rp);
        end
      end
      C_REF:   rfc_d = sat_dec(t_rfc);
      default: ;
    endcase

    valid_d = (cmd != C_NOP);
    cmd_d   = cmd;
    ba_d    = valid_d ? dfi_ba : '0;
    addr_d  = valid_d ? dfi_addr : '0;
    pulse_d = |err_vec;

    // a clear in the same cycle as a new error re-arms capture
    err_d  = err_q;
    code_d = code_q;
    if (pulse_d && (!err_q || err_clr_i)) begin
      err_d  = 1'b1;
      code_d = code;
    end else if (err_clr_i) begin
      err_d  = 1'b0;
      code_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q  <= '0;
      rfc_q   <= '0;
      rrd_q   <= '0;
      ccd_q   <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        rcd_q[b] <= '0;
        rp_q[b]  <= '0;
        ras_q[b] <= '0;
        rtp_q[b] <= '0;
        wtp_q[b] <= '0;
      end
      valid_q <= 1'b0;
      cmd_q   <= C_NOP;
      ba_q    <= '0;
      addr_q  <= '0;
      pulse_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      open_q  <= open_d;
      rfc_q   <= rfc_d;
      rrd_q   <= rrd_d;
      ccd_q   <= ccd_d;
      for (int b = 0; b < NUM_BANKS; b++) begin
        rcd_q[b] <= rcd_d[b];
        rp_q[b]  <= rp_d[b];
        ras_q[b] <= ras_d[b];
        rtp_q[b] <= rtp_d[b];
        wtp_q[b] <= wtp_d[b];
      end
      valid_q <= valid_d;
      cmd_q   <= cmd_d;
      ba_q    <= ba_d;
      addr_q  <= addr_d;
      pulse_q <= pulse_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign cmd_valid_o = valid_q;
  assign cmd_o       = cmd_q;
  assign cmd_ba_o    = ba_q;
  assign cmd_addr_o  = addr_q;
  assign bank_open_o = open_q;
  assign err_pulse_o = pulse_q;
  assign err_o       = err_q;
  assign err_code_o  = code_q;

endmodule
